// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// The slave modport is the controller's view; master is the driver/observer side.
interface pll_reset_ctrl_if;
  logic       extlock;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic       fail;
  logic [3:0] retries;

  modport master (
    output extlock,
    input  pll_reset,
    input  sys_reset,
    input  locked,
    input  fail,
    input  retries
  );

  modport slave (
    input  extlock,
    output pll_reset,
    output sys_reset,
    output locked,
    output fail,
    output retries
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL power-up sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset; retries on lock timeout and parks in FAIL once retries are exhausted.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 24,
  parameter int unsigned LOCK_TIMEOUT  = 24000,
  parameter int unsigned STABLE_CYCLES = 240,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic              refclk,
  input  logic              reset,
  pll_reset_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LockLast = 16'(LOCK_TIMEOUT - 1);
  // The lock sample that moves WAIT_LOCK into STABLE is the first of the stable run.
  localparam logic [15:0] StableLast = (STABLE_CYCLES > 1) ? 16'(STABLE_CYCLES - 2) : 16'd0;
  localparam logic [3:0]  MaxRetry   = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retries_q, retries_d;
  logic        sync1_q;
  logic        lock_s;
  logic        pll_reset_q, pll_reset_d;
  logic        sys_reset_q, sys_reset_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          cnt_d = '0;
          if (retries_q < MaxRetry) begin
            retries_d = retries_q + 4'd1;
            state_d   = StPllRst;
          end else begin
            state_d = StFail;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d   = StPllRst;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StFail;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change with the state.
  always_comb begin
    pll_reset_d = (state_d == StPllRst) || (state_d == StFail);
    sys_reset_d = (state_d != StRun);
    locked_d    = (state_d == StRun);
    fail_d      = (state_d == StFail);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= bus.extlock;
      lock_s      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.retries   = retries_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short timing parameters; all samples and drives
// happen 1 ns after the rising refclk edge.
module tb_pll_reset_ctrl;

  localparam int SigPll    = 0;
  localparam int SigSys    = 1;
  localparam int SigLocked = 2;
  localparam int SigFail   = 3;

  logic refclk = 1'b0;
  logic reset  = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;
  int   pll_rises  = 0;
  logic pll_prev   = 1'b0;

  pll_reset_ctrl_if ifc ();

  pll_reset_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (50),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .refclk(refclk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 refclk = ~refclk;

  always @(negedge refclk) begin
    if (ifc.pll_reset === 1'b1 && pll_prev === 1'b0) pll_rises <= pll_rises + 1;
    pll_prev <= ifc.pll_reset;
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      SigPll:    return ifc.pll_reset;
      SigSys:    return ifc.sys_reset;
      SigLocked: return ifc.locked;
      default:   return ifc.fail;
    endcase
  endfunction

  // Ticks until the selected output equals val; n = budget + 1 when it never does.
  task automatic wait_sig(input int s, input logic val, input int budget, output int n);
    n = 0;
    while (n <= budget) begin
      tick();
      n++;
      if (sig(s) === val) return;
    end
  endtask

  task automatic check_state(input string tag, input logic pll, input logic sys,
                             input logic lck, input logic fl, input logic [3:0] rt);
    check({tag, "_pll_reset"}, 32'(ifc.pll_reset), 32'(pll));
    check({tag, "_sys_reset"}, 32'(ifc.sys_reset), 32'(sys));
    check({tag, "_locked"},    32'(ifc.locked),    32'(lck));
    check({tag, "_fail"},      32'(ifc.fail),      32'(fl));
    check({tag, "_retries"},   32'(ifc.retries),   32'(rt));
  endtask

  initial begin
    int n;
    int lows;
    int snap;
    ifc.extlock = 1'b0;

    // Reset state
    repeat (3) tick();
    check_state("reset", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Timeout path: extlock stuck low, two retries then FAIL
    reset = 1'b0;
    wait_sig(SigPll, 1'b0, 20, n);
    check("first_pulse_len", n, 4);
    wait_sig(SigPll, 1'b1, 100, n);
    check("timeout1_cycles", n, 50);
    check("retries_after_1", 32'(ifc.retries), 1);
    wait_sig(SigPll, 1'b0, 20, n);
    check("retry1_pulse_len", n, 4);
    wait_sig(SigPll, 1'b1, 100, n);
    check("timeout2_cycles", n, 50);
    check("retries_after_2", 32'(ifc.retries), 2);
    wait_sig(SigPll, 1'b0, 20, n);
    check("retry2_pulse_len", n, 4);
    wait_sig(SigFail, 1'b1, 100, n);
    check("fail_cycles", n, 50);
    check_state("fail", 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    lows = 0;
    repeat (100) begin
      tick();
      if (ifc.pll_reset !== 1'b1 || ifc.fail !== 1'b1) lows++;
    end
    check("fail_held", lows, 0);

    // Reset out of FAIL, then the nominal sequence
    reset = 1'b1;
    tick();
    check_state("rst_in_fail", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    wait_sig(SigPll, 1'b0, 20, n);
    check("nom_pulse_len", n, 4);
    repeat (10) tick();
    ifc.extlock = 1'b1;
    wait_sig(SigSys, 1'b0, 40, n);
    check("nom_sys_release", n, 10);
    check_state("nom_run", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Reset mid-RUN, then the nominal sequence with a one-cycle lock glitch in STABLE
    reset = 1'b1;
    ifc.extlock = 1'b0;
    tick();
    check_state("rst_in_run", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    wait_sig(SigPll, 1'b0, 20, n);
    check("rerun_pulse_len", n, 4);
    repeat (10) tick();
    ifc.extlock = 1'b1;
    repeat (5) tick();
    ifc.extlock = 1'b0;
    tick();
    ifc.extlock = 1'b1;
    snap = pll_rises;
    wait_sig(SigSys, 1'b0, 40, n);
    check("glitch_sys_release", n, 10);
    check("glitch_no_pulse", pll_rises - snap, 0);
    check_state("glitch_run", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Lock loss in RUN, one timeout retry, then lock arriving on the timeout cycle
    ifc.extlock = 1'b0;
    wait_sig(SigLocked, 1'b0, 20, n);
    check("loss1_locked_fall", n, 3);
    check_state("loss1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_sig(SigPll, 1'b0, 20, n);
    check("loss1_pulse_len", n, 4);
    wait_sig(SigPll, 1'b1, 100, n);
    check("pre_coinc_timeout", n, 50);
    check("pre_coinc_retries", 32'(ifc.retries), 1);
    wait_sig(SigPll, 1'b0, 20, n);
    check("pre_coinc_pulse_len", n, 4);
    repeat (47) tick();
    ifc.extlock = 1'b1;
    snap = pll_rises;
    wait_sig(SigSys, 1'b0, 40, n);
    check("coinc_sys_release", n, 10);
    check("coinc_no_pulse", pll_rises - snap, 0);
    check_state("coinc_run", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);

    // Lock loss clears the retry count
    ifc.extlock = 1'b0;
    wait_sig(SigLocked, 1'b0, 20, n);
    check("loss2_locked_fall", n, 3);
    check_state("loss2", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_sig(SigPll, 1'b0, 20, n);
    check("loss2_pulse_len", n, 4);
    check("loss2_retries", 32'(ifc.retries), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
